// File: rtl/usb_bit_unstuffer.sv
// Removes the stuffed 0 after every six consecutive 1s and flags a seventh 1 as a sticky stuff error.
// Latency: 1 cycle, all outputs registered; one bit per cycle sustained.
// Backpressure: none; the output is a gapped stream qualified by out_valid.
// Optional removed-bit counter is built only when USB_UNSTUFF_CNT_EN is defined; otherwise stuff_cnt is 0.
module usb_bit_unstuffer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             clear,
  output logic             out_bit,
  output logic             out_valid,
  output logic             stuff_err,
  output logic [CNT_W-1:0] stuff_cnt
);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_DROP   = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] one_count_q, one_count_d;
  logic       out_bit_q, out_bit_d;
  logic       out_valid_q, out_valid_d;
  logic       stuff_err_q, stuff_err_d;

  // State register plus registered outputs; reset discards any run in progress.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_NORMAL;
      one_count_q <= 3'd0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      stuff_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      one_count_q <= one_count_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      stuff_err_q <= stuff_err_d;
    end
  end

  // Next-state: clear wins over a simultaneous input bit; idle cycles hold everything but out_valid.
  always_comb begin
    state_d     = state_q;
    one_count_d = one_count_q;
    out_bit_d   = out_bit_q;
    out_valid_d = 1'b0;
    stuff_err_d = stuff_err_q;

    if (clear) begin
      state_d     = ST_NORMAL;
      one_count_d = 3'd0;
      stuff_err_d = 1'b0;
    end else if (in_valid) begin
      case (state_q)
        ST_NORMAL: begin
          out_valid_d = 1'b1;
          out_bit_d   = in_bit;
          if (!in_bit) begin
            one_count_d = 3'd0;
          end else if (one_count_q == 3'd5) begin
            // Sixth 1 is still emitted; the following bit must be the stuffed 0.
            one_count_d = 3'd0;
            state_d     = ST_DROP;
          end else begin
            one_count_d = one_count_q + 3'd1;
          end
        end
        ST_DROP: begin
          if (!in_bit) begin
            one_count_d = 3'd0;
            state_d     = ST_NORMAL;
          end else begin
            stuff_err_d = 1'b1;
            state_d     = ST_ERROR;
          end
        end
        default: begin
          // ERROR: swallow all input until clear.
        end
      endcase
    end
  end

  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign stuff_err = stuff_err_q;

`ifdef USB_UNSTUFF_CNT_EN
  logic             cnt_inc;
  logic [CNT_W-1:0] stuff_cnt_q, stuff_cnt_d;

  // A stuff bit is removed exactly when a 0 is consumed in DROP without a clear.
  assign cnt_inc = in_valid && !clear && (state_q == ST_DROP) && !in_bit;

  // Saturating count of removed stuff bits since the last clear.
  always_comb begin
    stuff_cnt_d = stuff_cnt_q;
    if (clear) begin
      stuff_cnt_d = '0;
    end else if (cnt_inc && (stuff_cnt_q != {CNT_W{1'b1}})) begin
      stuff_cnt_d = stuff_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      stuff_cnt_q <= '0;
    end else begin
      stuff_cnt_q <= stuff_cnt_d;
    end
  end

  assign stuff_cnt = stuff_cnt_q;
`else
  assign stuff_cnt = '0;
`endif

endmodule
